// File: rtl/gcd_lcm.sv
// gcd_lcm: least common multiple from an operand pair and its GCD.
//
// Computes lcm = (a / gcd) * b with a restoring divider (XLEN cycles,
// quotient MSB first) followed by a shift-add multiplier (XLEN cycles,
// multiplier LSB first). An upstream GCD engine's valid/result can drive
// valid_i/gcd_i directly. err_o flags a gcd that does not divide a exactly;
// lcm_o then carries the product of the truncated quotient.
//
// Optional build macro: LCM_EARLY_EXIT_EN
//   When defined, the multiply phase stops as soon as the unconsumed
//   quotient bits are all zero (variable latency, identical results).
//
// Ports:
//   clk_i     in   clock, rising edge
//   reset_i   in   synchronous active-high reset
//   valid_i   in   request valid
//   ready_o   out  request can be accepted (IDLE only)
//   a_i       in   operand a        [XLEN-1:0]
//   b_i       in   operand b        [XLEN-1:0]
//   gcd_i     in   gcd(a, b)        [XLEN-1:0]
//   valid_o   out  result valid (DONE)
//   ready_i   in   downstream accepts result
//   lcm_o     out  result          [2*XLEN-1:0]
//   err_o     out  gcd_i does not divide a_i / zero gcd with nonzero operand
//
// state | meaning
// IDLE  | waiting for a request, ready_o=1
// DIV   | restoring divide a / gcd, one quotient bit per cycle
// MUL   | shift-add multiply quotient * b, one multiplier bit per cycle
// DONE  | result presented on lcm_o/err_o with valid_o=1

module gcd_lcm #(
    parameter int XLEN = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [XLEN-1:0]     a_i,
    input  logic [XLEN-1:0]     b_i,
    input  logic [XLEN-1:0]     gcd_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [2*XLEN-1:0]   lcm_o,
    output logic                err_o
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, DIV, MUL, DONE} state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0]   dvd_q;      // dividend shifts out MSB first, quotient shifts in
    logic [XLEN-1:0]   gcd_q;
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   rem_q;      // remainder is always < gcd, so XLEN bits suffice
    logic [XLEN-1:0]   mplier_q;
    logic [2*XLEN-1:0] mcand_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CW-1:0]     cnt_q;
    logic              err_pend_q;
    logic [2*XLEN-1:0] lcm_q;
    logic              err_q;

    logic              zero_case;
    logic [XLEN:0]     trial;      // (XLEN+1)-bit partial remainder
    logic [XLEN:0]     trial_diff;
    logic              sub_ok;
    logic [XLEN:0]     rem_next;
    logic [XLEN-1:0]   quot_next;
    logic [2*XLEN-1:0] acc_next;
    logic              cnt_done;
    logic              mul_last;

    assign zero_case  = (a_i == '0) || (b_i == '0) || (gcd_i == '0);
    assign trial      = {rem_q, dvd_q[XLEN-1]};
    assign trial_diff = trial - {1'b0, gcd_q};
    assign sub_ok     = (trial >= {1'b0, gcd_q});
    assign rem_next   = sub_ok ? trial_diff : trial;
    assign quot_next  = {dvd_q[XLEN-2:0], sub_ok};
    assign acc_next   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign cnt_done   = (cnt_q == '0);

`ifdef LCM_EARLY_EXIT_EN
    // Once the bits still to be shifted in are zero, acc_next is final.
    assign mul_last = cnt_done || (mplier_q[XLEN-1:1] == '0);
`else
    assign mul_last = cnt_done;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (valid_i)  state_d = zero_case ? DONE : DIV;
            DIV:  if (cnt_done) state_d = MUL;
            MUL:  if (mul_last) state_d = DONE;
            DONE: if (ready_i)  state_d = IDLE;
            default:            state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dvd_q      <= '0;
            gcd_q      <= '0;
            b_q        <= '0;
            rem_q      <= '0;
            mplier_q   <= '0;
            mcand_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            err_pend_q <= 1'b0;
            lcm_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        dvd_q <= a_i;
                        gcd_q <= gcd_i;
                        b_q   <= b_i;
                        rem_q <= '0;
                        cnt_q <= CW'(XLEN - 1);
                        if (zero_case) begin
                            lcm_q <= '0;
                            err_q <= (gcd_i == '0) && ((a_i | b_i) != '0);
                        end
                    end
                end
                DIV: begin
                    rem_q <= rem_next[XLEN-1:0];
                    dvd_q <= quot_next;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_done) begin
                        err_pend_q <= (rem_next != '0);
                        mplier_q   <= quot_next;
                        mcand_q    <= {{XLEN{1'b0}}, b_q};
                        acc_q      <= '0;
                        cnt_q      <= CW'(XLEN - 1);
                    end
                end
                MUL: begin
                    acc_q    <= acc_next;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - 1'b1;
                    // Outputs only change on DONE entry so they stay stable elsewhere.
                    if (mul_last) begin
                        lcm_q <= acc_next;
                        err_q <= err_pend_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);
    assign lcm_o   = lcm_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_gcd_lcm.sv
module tb_gcd_lcm;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] a_i, b_i, gcd_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] lcm_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    gcd_lcm #(.XLEN(16)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .b_i     (b_i),
        .gcd_i   (gcd_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .lcm_o   (lcm_o),
        .err_o   (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: {err, lcm} straight from the arithmetic definition.
    function automatic logic [32:0] model(input longint unsigned a, b, g);
        longint unsigned p;
        if (a == 0 || b == 0 || g == 0)
            return {(g == 0) && ((a | b) != 0), 32'd0};
        p = (a / g) * b;
        return {(a % g) != 0, p[31:0]};
    endfunction

    function automatic int unsigned euclid(input int unsigned x, y);
        int unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Called #1 after a rising edge with the DUT in IDLE. Returns the cycle
    // (relative to the accept edge) at which valid_o was first seen.
    task automatic run_op(input string tag, input logic [15:0] a, b, g,
                          input int hold, output int lat);
        logic [32:0] exp;
        bit          busy_ok;
        logic [31:0] held_lcm;
        exp = model(a, b, g);
        check({tag, "_ready_idle"}, ready_o, 1);
        a_i = a; b_i = b; gcd_i = g; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        a_i = $urandom; b_i = $urandom; gcd_i = $urandom;
        lat = 1;
        busy_ok = 1'b1;
        while (valid_o !== 1'b1 && lat < 200) begin
            if (ready_o !== 1'b0) busy_ok = 1'b0;
            @(posedge clk_i); #1;
            lat++;
        end
        check({tag, "_valid_seen"}, valid_o, 1);
        check({tag, "_ready_low_busy"}, busy_ok, 1);
        check({tag, "_ready_low_done"}, ready_o, 0);
        check({tag, "_lcm"}, lcm_o, exp[31:0]);
        check({tag, "_err"}, err_o, exp[32]);
        held_lcm = lcm_o;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i); #1;
            check({tag, "_hold_valid"}, valid_o, 1);
            check({tag, "_hold_lcm"}, lcm_o, held_lcm);
        end
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        check({tag, "_back_idle_ready"}, ready_o, 1);
        check({tag, "_back_idle_valid"}, valid_o, 0);
        check({tag, "_lcm_retained"}, lcm_o, exp[31:0]);
    endtask

    task automatic check_lat(input string tag, input logic [15:0] a, b, g, input int lat);
        if (a == 0 || b == 0 || g == 0) begin
            check({tag, "_lat_zero"}, lat, 1);
        end else begin
`ifdef LCM_EARLY_EXIT_EN
            check({tag, "_lat_range"}, (lat >= 18 && lat <= 33), 1);
`else
            check({tag, "_lat_fixed"}, lat, 33);
`endif
        end
    endtask

    initial begin
        int lat;
        int unsigned g0, x, y, g;
        logic [15:0] ta [6] = '{16'd1701, 16'd22000, 16'd42000, 16'd17, 16'd40664, 16'd48};
        logic [15:0] tb [6] = '{16'd199, 16'd19900, 16'd1990, 16'd289, 16'd57408, 16'd18};
        logic [15:0] tg [6] = '{16'd1, 16'd100, 16'd10, 16'd17, 16'd2392, 16'd5};

        reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
        a_i = '0; b_i = '0; gcd_i = '0;
        repeat (3) @(posedge clk_i);
        #1 reset_i = 1'b0;
        check("rst_ready", ready_o, 1);
        check("rst_valid", valid_o, 0);
        check("rst_lcm", lcm_o, 0);
        check("rst_err", err_o, 0);

        run_op("basic", 16'd48, 16'd18, 16'd6, 0, lat);
        check("basic_lat", lat, 33);
        check("basic_val", lcm_o, 144);

        for (int i = 0; i < 6; i++) begin
            run_op("table", ta[i], tb[i], tg[i], 0, lat);
            check_lat("table", ta[i], tb[i], tg[i], lat);
        end
        check("err_48_18_5", err_o, 1);

        run_op("bp", 16'd48, 16'd18, 16'd6, 10, lat);

        run_op("z_0_5_5", 16'd0, 16'd5, 16'd5, 0, lat);
        check("z_0_5_5_lat", lat, 1);
        run_op("z_0_0_0", 16'd0, 16'd0, 16'd0, 0, lat);
        check("z_0_0_0_lat", lat, 1);
        run_op("z_7_3_0", 16'd7, 16'd3, 16'd0, 0, lat);
        check("z_7_3_0_err", err_o, 1);

        // Reset five cycles into the divide phase.
        run_op("pre_rst", 16'd22000, 16'd19900, 16'd100, 0, lat);
        a_i = 16'd48; b_i = 16'd18; gcd_i = 16'd6; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (4) begin @(posedge clk_i); #1; end
        check("mid_busy", ready_o, 0);
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        check("mid_rst_ready", ready_o, 1);
        check("mid_rst_valid", valid_o, 0);
        check("mid_rst_lcm", lcm_o, 0);
        check("mid_rst_err", err_o, 0);
        run_op("after_rst", 16'd17, 16'd289, 16'd17, 0, lat);
`ifdef LCM_EARLY_EXIT_EN
        check("early_q1_fast", lat < 33, 1);
`else
        check("fixed_q1_lat", lat, 33);
`endif

        for (int i = 0; i < 24; i++) begin
            g0 = $urandom_range(1, 200);
            x  = g0 * $urandom_range(1, 300);
            y  = g0 * $urandom_range(1, 300);
            g  = euclid(x, y);
            case ($urandom_range(0, 7))
                0: g = $urandom_range(0, 60);
                1: x = 0;
                2: y = $urandom_range(0, 65535);
                default: ;
            endcase
            run_op("rand", 16'(x), 16'(y), 16'(g), $urandom_range(0, 2), lat);
            check_lat("rand", 16'(x), 16'(y), 16'(g), lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
